// File: rtl/mram_cmd_serializer_if.sv
// Command/response and serial-link bundle between
// the host and the MRAM command serializer.
interface mram_cmd_serializer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_byte_en;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              sps_rst;
  logic [2:0]        read_write_sel;
  logic              addr_in;
  logic              data_in;
  logic              ser_data_out;

  modport slave (
    input  cmd_valid, cmd_write, cmd_byte_en,
    input  cmd_addr, cmd_wdata, ser_data_out,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
    output sps_rst, read_write_sel, addr_in, data_in
  );

  modport master (
    output cmd_valid, cmd_write, cmd_byte_en,
    output cmd_addr, cmd_wdata, ser_data_out,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
    input  sps_rst, read_write_sel, addr_in, data_in
  );
endinterface

// File: rtl/mram_cmd_serializer.sv
// Turns one parallel MRAM command into the serial
// address/data streams and collects serial read data.
module mram_cmd_serializer #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 2,
  parameter int FLUSH_CYC = 2
) (
  input logic clk,
  input logic rst,
  mram_cmd_serializer_if.slave bus
);
  localparam int CW = $clog2(ADDR_W + 1);
  localparam int HB = DATA_W / 2;

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, RWAIT, CAPTURE, FLUSH
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_write;
  logic [1:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-2:0] r_shreg;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_sps_rst;
  logic [2:0]        r_rws;
  logic              r_addr_in;
  logic              r_data_in;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic [1:0]        w_be;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_mask;

  // An all-zero byte enable means a full-word access.
  assign w_be   = (bus.cmd_byte_en == 2'b00) ?
                  2'b11 : bus.cmd_byte_en;
  assign w_word = {r_shreg, bus.ser_data_out};
  assign w_mask = {{(DATA_W-HB){r_be[1]}},
                   {HB{r_be[0]}}};

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.busy           = r_busy;
  assign bus.sps_rst        = r_sps_rst;
  assign bus.read_write_sel = r_rws;
  assign bus.addr_in        = r_addr_in;
  assign bus.data_in        = r_data_in;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;

  // Transaction sequencer; outputs registered with the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_be        <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_shreg     <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_sps_rst   <= 1'b1;
      r_rws       <= 3'b000;
      r_addr_in   <= 1'b0;
      r_data_in   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_sps_rst   <= 1'b1;
          r_rws       <= 3'b000;
          r_addr_in   <= 1'b0;
          r_data_in   <= 1'b0;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_write     <= bus.cmd_write;
            r_be        <= w_be;
            r_addr      <= bus.cmd_addr;
            r_wdata     <= bus.cmd_write ?
                           bus.cmd_wdata : '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_sps_rst   <= 1'b0;
            r_rws       <= {w_be, bus.cmd_write};
            r_cnt       <= '0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_addr_in <= r_addr[0];
          r_data_in <= r_wdata[0];
          r_addr    <= r_addr >> 1;
          r_wdata   <= r_wdata >> 1;
          r_cnt     <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          if (r_cnt == CW'(ADDR_W - 1)) begin
            r_addr_in <= 1'b0;
            r_data_in <= 1'b0;
            r_cnt     <= '0;
            if (r_write) begin
              r_sps_rst <= 1'b1;
              r_rws     <= 3'b000;
              r_state   <= FLUSH;
            end else if (READ_LAT == 0) begin
              r_state <= CAPTURE;
            end else begin
              r_state <= RWAIT;
            end
          end else begin
            r_addr_in <= r_addr[0];
            r_data_in <= r_wdata[0];
            r_addr    <= r_addr >> 1;
            r_wdata   <= r_wdata >> 1;
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        RWAIT: begin
          if (r_cnt == CW'(READ_LAT - 1)) begin
            r_cnt   <= '0;
            r_state <= CAPTURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          r_shreg <= w_word[DATA_W-2:0];
          if (r_cnt == CW'(DATA_W - 1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_word & w_mask;
            r_sps_rst   <= 1'b1;
            r_rws       <= 3'b000;
            r_cnt       <= '0;
            r_state     <= FLUSH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (r_cnt == CW'(FLUSH_CYC - 1)) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mram_cmd_serializer.sv
// Directed and random checks of the MRAM command
// serializer against a cycle-timeline model.
module tb_mram_cmd_serializer;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned vec  = 0;
  int unsigned miss = 0;

  always #5 clk = ~clk;

  mram_cmd_serializer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mram_cmd_serializer #(
    .ADDR_W(AW), .DATA_W(DW),
    .READ_LAT(RL), .FLUSH_CYC(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sps_rst"}, 32'(bus.sps_rst), 1);
    chk({tag, " rws"}, 32'(bus.read_write_sel), 0);
    chk({tag, " addr_in"}, 32'(bus.addr_in), 0);
    chk({tag, " data_in"}, 32'(bus.data_in), 0);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 0);
  endtask

  // Cycle offset (from acceptance) of the first flush cycle.
  function automatic int flush_at(input logic w);
    return w ? AW + 2 : AW + 2 + RL + DW;
  endfunction

  function automatic int total_len(input logic w);
    return flush_at(w) + FC;
  endfunction

  task automatic run_cmd(
    input  logic          w,
    input  logic [1:0]    be,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] rword,
    input  bit            hold,
    input  int            abort_n,
    output int            t_acc
  );
    logic [1:0]    bee;
    logic [2:0]    rws;
    logic [DW-1:0] mask;
    int n0, tot, cb, i;
    bit ok;
    logic e_addr, e_data;
    string s;
    t_acc = -1;
    bee  = (be == 2'b00) ? 2'b11 : be;
    rws  = {bee, w};
    mask = {{8{bee[1]}}, {8{bee[0]}}};
    n0   = flush_at(w);
    tot  = total_len(w);
    cb   = AW + 2 + RL;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = w;
    bus.cmd_byte_en = be;
    bus.cmd_addr    = a;
    bus.cmd_wdata   = d;
    ok = 1'b0;
    for (i = 0; i < 60; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_wait", 32'(ok), 1);
    if (!ok) return;
    @(posedge clk);
    #1;
    t_acc = int'($time / 10);
    if (!hold) bus.cmd_valid = 1'b0;
    bus.cmd_write    = 1'($urandom);
    bus.cmd_byte_en  = 2'($urandom);
    bus.cmd_addr     = AW'($urandom);
    bus.cmd_wdata    = DW'($urandom);
    bus.ser_data_out = 1'($urandom);
    for (int n = 1; n <= tot; n++) begin
      @(negedge clk);
      s = $sformatf("w=%0d n=%0d", w, n);
      e_addr = (n >= 2 && n <= AW + 1) ?
               a[n-2] : 1'b0;
      e_data = (w && n >= 2 && n - 2 < DW) ?
               d[n-2] : 1'b0;
      chk({s, " cmd_ready"}, 32'(bus.cmd_ready),
          32'(n == tot));
      chk({s, " busy"}, 32'(bus.busy),
          32'(n < tot));
      chk({s, " sps_rst"}, 32'(bus.sps_rst),
          32'(n >= n0));
      chk({s, " rws"}, 32'(bus.read_write_sel),
          (n < n0) ? 32'(rws) : 0);
      chk({s, " addr_in"}, 32'(bus.addr_in),
          32'(e_addr));
      chk({s, " data_in"}, 32'(bus.data_in),
          32'(e_data));
      chk({s, " rsp_valid"}, 32'(bus.rsp_valid),
          32'(!w && n == n0));
      if (!w && n == n0)
        chk({s, " rsp_rdata"}, 32'(bus.rsp_rdata),
            32'(rword & mask));
      if (n == abort_n) begin
        #2 rst = 1'b0;
        #1 chk_reset("abort");
        repeat (4) begin
          @(negedge clk);
          chk_reset("abort_hold");
        end
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        return;
      end
      if (n >= cb && n < cb + DW)
        bus.ser_data_out = rword[DW-1-(n-cb)];
      else
        bus.ser_data_out = 1'($urandom);
    end
  endtask

  initial begin
    int t1, t2, t3;
    logic w1, w2;
    bus.cmd_valid    = 1'b0;
    bus.cmd_write    = 1'b0;
    bus.cmd_byte_en  = 2'b00;
    bus.cmd_addr     = '0;
    bus.cmd_wdata    = '0;
    bus.ser_data_out = 1'b0;

    repeat (3) begin
      @(negedge clk);
      bus.cmd_valid = 1'($urandom);
      chk_reset("reset");
    end
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1 chk("ready_at_release", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", 32'(bus.cmd_ready), 1);
    chk("sps_after_edge", 32'(bus.sps_rst), 1);
    chk("busy_after_edge", 32'(bus.busy), 0);

    run_cmd(1'b1, 2'b11, 20'h00000, 16'hAAAA,
            16'h0000, 1'b0, 0, t1);
    run_cmd(1'b1, 2'b01, 20'h00001, 16'h5555,
            16'h0000, 1'b0, 0, t1);
    run_cmd(1'b0, 2'b10, 20'h00002, 16'h0000,
            16'hA5C3, 1'b0, 0, t1);

    w1 = 1'b1;
    run_cmd(w1, 2'b11, AW'($urandom), DW'($urandom),
            DW'($urandom), 1'b1, 0, t1);
    for (int i = 0; i < 5; i++) begin
      w2 = 1'($urandom);
      run_cmd(w2, 2'($urandom), AW'($urandom),
              DW'($urandom), DW'($urandom),
              1'b1, 0, t2);
      chk($sformatf("b2b_gap %0d", i), 32'(t2 - t1),
          32'(total_len(w1)));
      t1 = t2;
      w1 = w2;
    end
    bus.cmd_valid = 1'b0;

    run_cmd(1'b0, 2'b11, AW'($urandom), 16'h0000,
            DW'($urandom), 1'b0, 12, t3);
    run_cmd(1'b0, 2'b01, AW'($urandom), 16'h0000,
            DW'($urandom), 1'b0, 0, t3);

    for (int i = 0; i < 10; i++)
      run_cmd(1'($urandom), 2'($urandom),
              AW'($urandom), DW'($urandom),
              DW'($urandom), 1'b0, 0, t3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end
endmodule
